// File: rtl/inst_prefetch_queue_if.sv
// inst_prefetch_queue_if: instruction request/response channel between prefetch queue and memory
interface inst_prefetch_queue_if;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  modport master (
    output PC, Inst_Req_Valid, Inst_Ready,
    input  Inst_Req_Ready, Instruction, Inst_Valid
  );
  modport slave (
    input  PC, Inst_Req_Valid, Inst_Ready,
    output Inst_Req_Ready, Instruction, Inst_Valid
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: runs sequential fetch ahead of decode, holding in-order {pc, inst} pairs with redirect flush
module inst_prefetch_queue #(
  parameter int          DEPTH        = 4,
  parameter int          MAX_INFLIGHT = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  inst_prefetch_queue_if.master        bus,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         out_valid,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_inst,
  input  logic                         out_ready,
  output logic [31:0]                  fetch_cnt,
  output logic [31:0]                  drop_cnt_total
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_INFLIGHT);
  logic [31:0]   pc_q, pc_d, redir_pc_q, redir_pc_d;
  logic [31:0]   fetch_cnt_q, fetch_cnt_d, drop_cnt_q, drop_cnt_d;
  logic          req_valid_q, req_valid_d, req_stale_q, req_stale_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, fill_ptr;
  logic [CW-1:0] cnt_q, cnt_d, inflight_q, inflight_d, stale_q, stale_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];
  logic          hs, hs_stale, hs_live, pend, pop, drop, fill;
  assign bus.PC             = pc_q;
  assign bus.Inst_Req_Valid = req_valid_q;
  assign bus.Inst_Ready     = 1'b1;
  assign out_valid      = (cnt_q != '0) && filled_q[head_q];
  assign out_pc         = out_valid ? pc_mem_q[head_q] : '0;
  assign out_inst       = out_valid ? inst_mem_q[head_q] : '0;
  assign fetch_cnt      = fetch_cnt_q;
  assign drop_cnt_total = drop_cnt_q;
  // a request handshaking in or after a redirect belongs to the old stream
  assign hs       = req_valid_q & bus.Inst_Req_Ready;
  assign hs_stale = hs & (req_stale_q | redirect_valid);
  assign hs_live  = hs & ~hs_stale;
  assign pend     = req_valid_q & ~bus.Inst_Req_Ready;
  assign pop      = out_valid & out_ready & ~redirect_valid;
  assign drop     = bus.Inst_Valid & ((stale_q != '0) | (redirect_valid & (inflight_q != '0)));
  assign fill     = bus.Inst_Valid & ~redirect_valid & (stale_q == '0) & (inflight_q != '0);
  // unfilled slots are exactly the youngest inflight_q reservations
  assign fill_ptr = tail_q - AW'(inflight_q);
  always_comb begin
    pc_d        = pc_q;
    redir_pc_d  = redir_pc_q;
    req_stale_d = req_stale_q;
    head_d      = head_q;
    tail_d      = tail_q;
    filled_d    = filled_q;
    pc_mem_d    = pc_mem_q;
    inst_mem_d  = inst_mem_q;
    fetch_cnt_d = fetch_cnt_q + {31'b0, pop};
    drop_cnt_d  = drop_cnt_q + {31'b0, drop};
    stale_d     = stale_q + CW'(hs_stale) - CW'(drop);
    if (redirect_valid) begin
      head_d      = '0;
      tail_d      = '0;
      filled_d    = '0;
      cnt_d       = '0;
      inflight_d  = '0;
      stale_d     = stale_q + inflight_q + CW'(hs_stale) - CW'(drop);
      pc_d        = pend ? pc_q : redirect_pc;
      redir_pc_d  = redirect_pc;
      req_stale_d = pend;
    end else begin
      if (hs_live) begin
        pc_mem_d[tail_q] = pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + AW'(1);
      end
      if (fill) begin
        inst_mem_d[fill_ptr] = bus.Instruction;
        filled_d[fill_ptr]   = 1'b1;
      end
      head_d     = pop ? head_q + AW'(1) : head_q;
      cnt_d      = cnt_q + CW'(hs_live) - CW'(pop);
      inflight_d = inflight_q + CW'(hs_live) - CW'(fill);
      if (hs) begin
        pc_d        = req_stale_q ? redir_pc_q : pc_q + 32'd4;
        req_stale_d = 1'b0;
      end
    end
    req_valid_d = pend | ((cnt_d < DEPTH_C) && (inflight_d + stale_d < MAX_C));
  end
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
    if (!rst) begin
      pc_q        <= RESET_PC;
      redir_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      req_stale_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      inflight_q  <= '0;
      stale_q     <= '0;
      filled_q    <= '0;
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      redir_pc_q  <= redir_pc_d;
      req_valid_q <= req_valid_d;
      req_stale_q <= req_stale_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      stale_q     <= stale_d;
      filled_q    <= filled_d;
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: scenario tasks against a queue-based model of the prefetch buffer and a memory responder
module tb_inst_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int MAXI  = 2;
  localparam logic [31:0] RPC = 32'h0;
  logic clk = 0, rst = 0, redirect_valid = 0, out_ready = 0;
  logic [31:0] redirect_pc = 0;
  logic out_valid;
  logic [31:0] out_pc, out_inst, fetch_cnt, drop_cnt_total;
  inst_prefetch_queue_if bus();
  inst_prefetch_queue #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAXI), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
    .fetch_cnt(fetch_cnt), .drop_cnt_total(drop_cnt_total)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] pc; int kind;} req_t;
  typedef struct {logic [31:0] pc; bit filled;} ent_t;
  req_t rq[$];
  ent_t ents[$];
  logic [31:0] pops[$];
  logic [31:0] exp_pc = RPC, redir_target = 0, fetch_m = 0, drop_m = 0, hs_pc = 0;
  bit taint = 0, exp_rv = 0, seen_hs = 0;
  int mode = 1, checks = 0, failures = 0;
  initial begin
    bus.Inst_Req_Ready = 0;
    bus.Inst_Valid = 0;
    bus.Instruction = 0;
  end
  function automatic logic [31:0] f(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
  endfunction
  function automatic int live_cnt();
    int n = 0;
    foreach (rq[i]) if (rq[i].kind != 2) n++;
    return n;
  endfunction
  // memory drives responses in order; model applies the cycle's events, then one clock passes
  task automatic cycle();
    bit hs, red, pop, pend;
    req_t r;
    ent_t e;
    if (rq.size() > 0 && (mode == 0 || (mode == 2 && $urandom_range(0, 1) == 1))) begin
      bus.Inst_Valid = 1; bus.Instruction = f(rq[0].pc);
    end else begin
      bus.Inst_Valid = 0; bus.Instruction = $urandom();
    end
    hs   = rst && bus.Inst_Req_Valid && bus.Inst_Req_Ready;
    pend = rst && bus.Inst_Req_Valid && !bus.Inst_Req_Ready;
    red  = rst && redirect_valid;
    pop  = rst && !red && out_valid && out_ready;
    seen_hs = hs;
    hs_pc = bus.PC;
    if (bus.Inst_Valid) begin
      r = rq.pop_front();
      if (rst && r.kind == 0 && !red) begin
        for (int i = 0; i < ents.size(); i++) if (!ents[i].filled) begin ents[i].filled = 1; break; end
      end else if (rst && r.kind != 2) drop_m++;
    end
    if (!rst) begin
      foreach (rq[i]) rq[i].kind = 2;
      ents.delete(); exp_pc = RPC; taint = 0; fetch_m = 0; drop_m = 0;
    end else begin
      if (pop && ents.size() > 0) begin pops.push_back(out_pc); void'(ents.pop_front()); fetch_m++; end
      if (red) begin
        foreach (rq[i]) if (rq[i].kind == 0) rq[i].kind = 1;
        ents.delete();
      end
      if (hs) begin
        r.pc = exp_pc; r.kind = (taint || red) ? 1 : 0; rq.push_back(r);
        if (r.kind == 0) begin e.pc = exp_pc; e.filled = 0; ents.push_back(e); end
        exp_pc = red ? redirect_pc : taint ? redir_target : exp_pc + 32'd4;
        taint = 0;
      end else if (red) begin
        if (pend) begin taint = 1; redir_target = redirect_pc; end
        else exp_pc = redirect_pc;
      end
    end
    exp_rv = rst && (pend || (ents.size() < DEPTH && live_cnt() < MAXI));
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset(input bit keep);
    rst = 0; redirect_valid = 0; out_ready = 0; bus.Inst_Req_Ready = 0;
    cycle();
    rst = 1;
    if (!keep) rq.delete();
    pops.delete();
  endtask
  task automatic test_reset();
    mode = 1;
    do_reset(0);
    checks += 8;
    if (bus.Inst_Req_Valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", bus.Inst_Req_Valid); end
    if (bus.PC !== RPC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.PC, RPC); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    if (out_inst !== 32'h0) begin failures++; $display("FAIL reset_out_inst got=%h exp=0", out_inst); end
    if (bus.Inst_Ready !== 1'b1) begin failures++; $display("FAIL reset_inst_ready got=%b exp=1", bus.Inst_Ready); end
    if (fetch_cnt !== 32'h0) begin failures++; $display("FAIL reset_fetch_cnt got=%0d exp=0", fetch_cnt); end
    if (drop_cnt_total !== 32'h0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt_total); end
    cycle();
    checks++;
    if (bus.Inst_Req_Valid !== 1'b1 || bus.PC !== RPC) begin
      failures++; $display("FAIL first_req valid=%b pc=%h exp valid=1 pc=%h", bus.Inst_Req_Valid, bus.PC, RPC);
    end
  endtask
  task automatic test_stream();
    bit ov;
    do_reset(0);
    mode = 0; bus.Inst_Req_Ready = 1; out_ready = 1;
    for (int c = 0; c < 24; c++) begin
      cycle();
      checks++; if (bus.Inst_Req_Valid !== exp_rv) begin failures++; $display("FAIL stream_req_valid got=%b exp=%b", bus.Inst_Req_Valid, exp_rv); end
      if (exp_rv) begin checks++; if (bus.PC !== exp_pc) begin failures++; $display("FAIL stream_pc got=%h exp=%h", bus.PC, exp_pc); end end
      ov = ents.size() > 0 && ents[0].filled;
      checks++; if (out_valid !== ov) begin failures++; $display("FAIL stream_out_valid got=%b exp=%b", out_valid, ov); end
      if (ov) begin checks++; if (out_pc !== ents[0].pc || out_inst !== f(ents[0].pc)) begin failures++; $display("FAIL stream_out got=%h/%h exp=%h/%h", out_pc, out_inst, ents[0].pc, f(ents[0].pc)); end end
    end
    checks++;
    if (pops.size() < 8) begin failures++; $display("FAIL stream_pop_count got=%0d exp>=8", pops.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks++; if (pops[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, pops[i], 32'(4 * i)); end
    end
    checks++; if (fetch_cnt !== 32'(pops.size())) begin failures++; $display("FAIL stream_fetch_cnt got=%0d exp=%0d", fetch_cnt, pops.size()); end
  endtask
  task automatic test_full();
    int n = 0;
    do_reset(0);
    mode = 0; bus.Inst_Req_Ready = 1; out_ready = 0;
    for (int c = 0; c < 14; c++) begin cycle(); if (seen_hs) n++; end
    checks += 3;
    if (n != DEPTH) begin failures++; $display("FAIL full_req_count got=%0d exp=%0d", n, DEPTH); end
    if (bus.Inst_Req_Valid !== 1'b0) begin failures++; $display("FAIL full_req_valid got=%b exp=0", bus.Inst_Req_Valid); end
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL full_head got=%b/%h exp=1/0", out_valid, out_pc); end
    out_ready = 1; cycle(); out_ready = 0;
    n = 0;
    while (n < 8) begin cycle(); n++; if (seen_hs) break; end
    checks++;
    if (!seen_hs || hs_pc !== 32'h10) begin failures++; $display("FAIL full_next_req hs=%b pc=%h exp=1/00000010", seen_hs, hs_pc); end
  endtask
  task automatic test_hold();
    int n = 0;
    do_reset(0);
    mode = 0; bus.Inst_Req_Ready = 0;
    cycle();
    for (int c = 0; c < 5; c++) begin
      cycle(); if (seen_hs) n++;
      checks++; if (bus.Inst_Req_Valid !== 1'b1 || bus.PC !== 32'h0) begin failures++; $display("FAIL hold_stable valid=%b pc=%h exp=1/0", bus.Inst_Req_Valid, bus.PC); end
    end
    bus.Inst_Req_Ready = 1; cycle(); if (seen_hs) n++;
    bus.Inst_Req_Ready = 0;
    checks++; if (n != 1 || hs_pc !== 32'h0) begin failures++; $display("FAIL hold_handshake count=%0d pc=%h exp=1/0", n, hs_pc); end
    cycle();
    checks++; if (bus.PC !== 32'h4) begin failures++; $display("FAIL hold_next_pc got=%h exp=4", bus.PC); end
  endtask
  task automatic test_redirect_inflight();
    int n = 0;
    do_reset(0);
    mode = 0; bus.Inst_Req_Ready = 1; out_ready = 1;
    while (n < 40 && exp_pc != 32'h8) begin cycle(); n++; end
    bus.Inst_Req_Ready = 0;
    while (n < 40 && rq.size() != 0) begin cycle(); n++; end
    mode = 1; bus.Inst_Req_Ready = 1;
    while (n < 40 && live_cnt() != 2) begin cycle(); n++; end
    bus.Inst_Req_Ready = 0;
    checks++; if (n >= 40 || exp_pc !== 32'h10) begin failures++; $display("FAIL redir_setup timeout n=%0d exp_pc=%h", n, exp_pc); end
    pops.delete();
    redirect_valid = 1; redirect_pc = 32'h100; cycle(); redirect_valid = 0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_flush out_valid=%b exp=0", out_valid); end
    mode = 0; bus.Inst_Req_Ready = 1;
    for (int c = 0; c < 16; c++) begin
      cycle();
      checks++; if (out_valid && (out_pc == 32'h8 || out_pc == 32'hC)) begin failures++; $display("FAIL redir_stale_visible pc=%h", out_pc); end
    end
    checks += 2;
    if (drop_cnt_total !== 32'd2) begin failures++; $display("FAIL redir_drop_cnt got=%0d exp=2", drop_cnt_total); end
    if (pops.size() == 0 || pops[0] !== 32'h100) begin failures++; $display("FAIL redir_first_out got=%h exp=00000100", pops.size() ? pops[0] : 32'hX); end
  endtask
  task automatic test_redirect_pending();
    int n = 0;
    logic [31:0] hs1 = '1, hs2 = '1;
    do_reset(0);
    mode = 0; bus.Inst_Req_Ready = 1; out_ready = 1;
    while (n < 40 && exp_pc != 32'h20) begin cycle(); n++; end
    bus.Inst_Req_Ready = 0;
    while (n < 40 && !(rq.size() == 0 && bus.Inst_Req_Valid)) begin cycle(); n++; end
    checks++; if (n >= 40 || bus.PC !== 32'h20) begin failures++; $display("FAIL pend_setup n=%0d pc=%h exp=00000020", n, bus.PC); end
    pops.delete();
    redirect_valid = 1; redirect_pc = 32'h200; cycle(); redirect_valid = 0;
    for (int c = 0; c < 2; c++) begin
      cycle();
      checks++; if (bus.Inst_Req_Valid !== 1'b1 || bus.PC !== 32'h20) begin failures++; $display("FAIL pend_hold valid=%b pc=%h exp=1/00000020", bus.Inst_Req_Valid, bus.PC); end
    end
    bus.Inst_Req_Ready = 1; n = 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (seen_hs) begin if (n == 0) hs1 = hs_pc; else if (n == 1) hs2 = hs_pc; n++; end
    end
    checks += 4;
    if (hs1 !== 32'h20) begin failures++; $display("FAIL pend_first_req got=%h exp=00000020", hs1); end
    if (hs2 !== 32'h200) begin failures++; $display("FAIL pend_second_req got=%h exp=00000200", hs2); end
    if (drop_cnt_total !== 32'd1) begin failures++; $display("FAIL pend_drop_cnt got=%0d exp=1", drop_cnt_total); end
    if (pops.size() == 0 || pops[0] !== 32'h200) begin failures++; $display("FAIL pend_first_out got=%h exp=00000200", pops.size() ? pops[0] : 32'hX); end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    do_reset(0);
    mode = 0; bus.Inst_Req_Ready = 1; out_ready = 0;
    while (n < 40 && exp_pc != 32'hC) begin cycle(); n++; end
    mode = 1; bus.Inst_Req_Ready = 0;
    checks++; if (n >= 40 || live_cnt() != 1 || ents.size() != 3) begin failures++; $display("FAIL rmid_setup n=%0d inflight=%0d entries=%0d exp 1/3", n, live_cnt(), ents.size()); end
    do_reset(1);
    checks += 4;
    if (bus.Inst_Req_Valid !== 1'b0 || bus.PC !== RPC) begin failures++; $display("FAIL rmid_req valid=%b pc=%h exp=0/%h", bus.Inst_Req_Valid, bus.PC, RPC); end
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin failures++; $display("FAIL rmid_out got=%b/%h/%h exp=0/0/0", out_valid, out_pc, out_inst); end
    if (fetch_cnt !== 32'h0 || drop_cnt_total !== 32'h0) begin failures++; $display("FAIL rmid_cnt got=%0d/%0d exp=0/0", fetch_cnt, drop_cnt_total); end
    if (bus.Inst_Ready !== 1'b1) begin failures++; $display("FAIL rmid_inst_ready got=%b exp=1", bus.Inst_Ready); end
    mode = 0; bus.Inst_Req_Ready = 1; out_ready = 1;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (out_valid) begin checks++; if (out_inst !== f(out_pc)) begin failures++; $display("FAIL rmid_late_data pc=%h got=%h exp=%h", out_pc, out_inst, f(out_pc)); end end
    end
    checks += 2;
    if (pops.size() == 0 || pops[0] !== RPC) begin failures++; $display("FAIL rmid_restart got=%h exp=%h", pops.size() ? pops[0] : 32'hX, RPC); end
    if (drop_cnt_total !== 32'h0) begin failures++; $display("FAIL rmid_drop got=%0d exp=0", drop_cnt_total); end
  endtask
  task automatic test_random();
    bit ov;
    do_reset(0);
    mode = 2;
    for (int c = 0; c < 800; c++) begin
      bus.Inst_Req_Ready = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      redirect_valid = $urandom_range(0, 15) == 0;
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
      cycle();
      checks++; if (bus.Inst_Req_Valid !== exp_rv) begin failures++; $display("FAIL rand_req_valid c=%0d got=%b exp=%b", c, bus.Inst_Req_Valid, exp_rv); end
      if (exp_rv) begin checks++; if (bus.PC !== exp_pc) begin failures++; $display("FAIL rand_pc c=%0d got=%h exp=%h", c, bus.PC, exp_pc); end end
      ov = ents.size() > 0 && ents[0].filled;
      checks++; if (out_valid !== ov) begin failures++; $display("FAIL rand_out_valid c=%0d got=%b exp=%b", c, out_valid, ov); end
      if (ov) begin checks++; if (out_pc !== ents[0].pc || out_inst !== f(ents[0].pc)) begin failures++; $display("FAIL rand_out c=%0d got=%h/%h exp=%h/%h", c, out_pc, out_inst, ents[0].pc, f(ents[0].pc)); end end
      checks++; if (fetch_cnt !== fetch_m || drop_cnt_total !== drop_m) begin failures++; $display("FAIL rand_counters c=%0d got=%0d/%0d exp=%0d/%0d", c, fetch_cnt, drop_cnt_total, fetch_m, drop_m); end
    end
    redirect_valid = 0;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_full();
    test_hold();
    test_redirect_inflight();
    test_redirect_pending();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
